// File: rtl/counter_arbiter_if.sv
// counter_arbiter_if: bundles the request/limit/count inputs and the
// grant/done/busy/counter_reset outputs of counter_arbiter.
//   slave  : arbiter side (req, limit, count in; counter_reset, grant, done, busy out)
//   master : requester/counter side (the opposite directions)
interface counter_arbiter_if #(
  parameter int Size   = 5,
  parameter int NumReq = 2
);
  logic [NumReq-1:0]      req;
  logic [NumReq*Size-1:0] limit;
  logic [Size-1:0]        count;
  logic                   counter_reset;
  logic [NumReq-1:0]      grant;
  logic [NumReq-1:0]      done;
  logic                   busy;

  modport slave (
    input  req, limit, count,
    output counter_reset, grant, done, busy
  );

  modport master (
    output req, limit, count,
    input  counter_reset, grant, done, busy
  );
endinterface

// File: rtl/counter_arbiter.sv
// counter_arbiter: shares one free-running counter among NumReq requesters.
// A round-robin winner is granted the counter, the counter is cleared for one
// cycle, and the winner gets a one-cycle done pulse once count equals the
// limit latched at grant time. Dropping the request while running aborts.
// Ports:
//   clock : rising-edge clock shared with the counter
//   reset : asynchronous active-low reset
//   bus   : slave modport of counter_arbiter_if
//           req/limit/count in, counter_reset/grant/done/busy out (all registered)
module counter_arbiter #(
  parameter int Size   = 5,
  parameter int NumReq = 2
) (
  input  logic               clock,
  input  logic               reset,
  counter_arbiter_if.slave   bus
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic [IdxW-1:0]   r_last;
  logic [IdxW-1:0]   r_owner;
  logic [Size-1:0]   r_limit_q;
  logic [NumReq-1:0] r_grant;
  logic [NumReq-1:0] r_done;
  logic              r_busy;
  logic              r_counter_reset;

  logic [Size-1:0]   w_limits [NumReq];
  logic              w_found;
  logic [IdxW-1:0]   w_win;
  logic [IdxW-1:0]   w_cand;

  // Modulo-NumReq increment, so non-power-of-two requester counts wrap correctly.
  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
    if (i == IdxW'(NumReq - 1)) begin
      return '0;
    end else begin
      return i + IdxW'(1);
    end
  endfunction

  for (genvar g = 0; g < NumReq; g++) begin : g_limit
    assign w_limits[g] = bus.limit[g*Size +: Size];
  end

  // Round-robin pick: first set req bit scanning upward from the one after r_last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = r_last;
    for (int k = 0; k < NumReq; k++) begin
      w_cand = next_idx(w_cand);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end else begin
        w_found = w_found;
      end
    end
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_last          <= IdxW'(NumReq - 1);
      r_owner         <= '0;
      r_limit_q       <= '0;
      r_grant         <= '0;
      r_done          <= '0;
      r_busy          <= 1'b0;
      r_counter_reset <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_counter_reset <= 1'b1;
          r_done          <= '0;
          if (w_found) begin
            r_owner   <= w_win;
            r_limit_q <= w_limits[w_win];
            r_grant   <= NumReq'(1) << w_win;
            r_busy    <= 1'b1;
            r_state   <= CLEAR;
          end else begin
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end
        CLEAR: begin
          // Counter has been held at 0 through this edge; release it.
          r_counter_reset <= 1'b0;
          r_state         <= RUN;
        end
        RUN: begin
          // Abort takes priority over reaching the limit on the same edge.
          if (!bus.req[r_owner]) begin
            r_grant         <= '0;
            r_busy          <= 1'b0;
            r_counter_reset <= 1'b1;
            r_last          <= r_owner;
            r_state         <= IDLE;
          end else if (bus.count == r_limit_q) begin
            r_done          <= r_grant;
            r_grant         <= '0;
            r_counter_reset <= 1'b1;
            r_state         <= DONE;
          end else begin
            r_state <= RUN;
          end
        end
        DONE: begin
          r_done  <= '0;
          r_busy  <= 1'b0;
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: begin
          r_state         <= IDLE;
          r_grant         <= '0;
          r_done          <= '0;
          r_busy          <= 1'b0;
          r_counter_reset <= 1'b1;
        end
      endcase
    end
  end

  assign bus.counter_reset = r_counter_reset;
  assign bus.grant         = r_grant;
  assign bus.done          = r_done;
  assign bus.busy          = r_busy;

endmodule
